// File: rtl/memc_port_arbiter_if.sv
// Bundle of every signal between the PE memory port arbiter, its clients
// (DMA lanes, SIMD load/store unit) and the single-port memory behind it.
interface memc_port_arbiter_if #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
);
  // DMA lanes: a lane transfers in a cycle where its valid and the matching
  // ready are both high; ready is combinational from valid, valid must not
  // wait for ready. At most one lane sees a ready in any cycle.
  logic [NUM_LANES-1:0]        dma__memc__write_valid;
  logic [NUM_LANES*ADDR_W-1:0] dma__memc__write_address;
  logic [NUM_LANES*DATA_W-1:0] dma__memc__write_data;
  logic [NUM_LANES-1:0]        dma__memc__read_valid;
  logic [NUM_LANES*ADDR_W-1:0] dma__memc__read_address;
  logic [NUM_LANES-1:0]        memc__dma__write_ready;
  logic [NUM_LANES-1:0]        memc__dma__read_ready;
  logic [NUM_LANES-1:0]        memc__dma__read_data_valid;
  logic [DATA_W-1:0]           memc__dma__read_data;

  // Load/store unit: session based ownership of the port.
  logic                        ldst__memc__request;
  logic                        ldst__memc__released;
  logic                        ldst__memc__write_valid;
  logic                        ldst__memc__read_valid;
  logic [ADDR_W-1:0]           ldst__memc__write_address;
  logic [ADDR_W-1:0]           ldst__memc__read_address;
  logic [DATA_W-1:0]           ldst__memc__write_data;
  logic                        memc__ldst__granted;
  logic                        memc__ldst__read_data_valid;
  logic [DATA_W-1:0]           memc__ldst__read_data;

  // Memory side: fixed-latency single port.
  logic                        arb__mem__enable;
  logic                        arb__mem__write;
  logic [ADDR_W-1:0]           arb__mem__address;
  logic [DATA_W-1:0]           arb__mem__write_data;
  logic [DATA_W-1:0]           mem__arb__read_data;

  // Arbiter view.
  modport slave (
    input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    input  dma__memc__read_valid, dma__memc__read_address,
    output memc__dma__write_ready, memc__dma__read_ready,
    output memc__dma__read_data_valid, memc__dma__read_data,
    input  ldst__memc__request, ldst__memc__released,
    input  ldst__memc__write_valid, ldst__memc__read_valid,
    input  ldst__memc__write_address, ldst__memc__read_address, ldst__memc__write_data,
    output memc__ldst__granted, memc__ldst__read_data_valid, memc__ldst__read_data,
    output arb__mem__enable, arb__mem__write, arb__mem__address, arb__mem__write_data,
    input  mem__arb__read_data
  );

  // Client and memory view.
  modport master (
    output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    output dma__memc__read_valid, dma__memc__read_address,
    input  memc__dma__write_ready, memc__dma__read_ready,
    input  memc__dma__read_data_valid, memc__dma__read_data,
    output ldst__memc__request, ldst__memc__released,
    output ldst__memc__write_valid, ldst__memc__read_valid,
    output ldst__memc__write_address, ldst__memc__read_address, ldst__memc__write_data,
    input  memc__ldst__granted, memc__ldst__read_data_valid, memc__ldst__read_data,
    input  arb__mem__enable, arb__mem__write, arb__mem__address, arb__mem__write_data,
    output mem__arb__read_data
  );
endinterface

// File: rtl/memc_port_arbiter.sv
// Shares one PE memory port between round-robin DMA lanes and an exclusive
// load/store session; read returns are steered by a fixed-latency tag pipe.
module memc_port_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MEM_RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset_poweron,
  memc_port_arbiter_if.slave bus,
  output logic [1:0]       dbg_state
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int LAST = MEM_RD_LAT - 1;

  typedef enum logic [1:0] {
    ST_DMA      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_LDST_OWN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] rr_ptr, rr_ptr_nxt;
  logic          dma_turn, dma_turn_nxt;

  // Return tag pipe: stage LAST lines up with the memory read data.
  logic [MEM_RD_LAT-1:0] pipe_valid;
  logic [MEM_RD_LAT-1:0] pipe_ldst;
  logic [LW-1:0]         pipe_lane [MEM_RD_LAT];

  logic [NUM_LANES-1:0] lane_req;
  logic                 win_found;
  logic [LW-1:0]        win_lane;
  int                   scan_idx;

  logic ldst_req_seen;
  logic dma_go;
  logic win_wr;
  logic ldst_go;
  logic ldst_wr;
  logic push_valid;
  logic push_ldst;
  logic pipe_hold;
  logic ret_valid;

  // Rotating priority scan starting at the pointer.
  always_comb begin
    lane_req  = bus.dma__memc__write_valid | bus.dma__memc__read_valid;
    win_found = 1'b0;
    win_lane  = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_LANES;
      if (!win_found && lane_req[scan_idx]) begin
        win_found = 1'b1;
        win_lane  = LW'(scan_idx);
      end
    end
  end

  // A request is only honoured once DMA has had its turn after a session.
  assign ldst_req_seen = (state == ST_DMA) && bus.ldst__memc__request && !dma_turn;
  assign dma_go  = (state == ST_DMA) && !ldst_req_seen && win_found && !reset_poweron;
  assign win_wr  = bus.dma__memc__write_valid[win_lane];
  assign ldst_go = (state == ST_LDST_OWN) && !reset_poweron &&
                   (bus.ldst__memc__write_valid || bus.ldst__memc__read_valid);
  assign ldst_wr = bus.ldst__memc__write_valid;

  assign push_valid = (dma_go && !win_wr) || (ldst_go && !ldst_wr);
  assign push_ldst  = ldst_go;

  always_comb begin
    bus.memc__dma__write_ready = '0;
    bus.memc__dma__read_ready  = '0;
    bus.arb__mem__enable       = 1'b0;
    bus.arb__mem__write        = 1'b0;
    bus.arb__mem__address      = '0;
    bus.arb__mem__write_data   = '0;
    if (dma_go) begin
      bus.arb__mem__enable = 1'b1;
      bus.arb__mem__write  = win_wr;
      if (win_wr) begin
        bus.memc__dma__write_ready = NUM_LANES'(1) << win_lane;
        bus.arb__mem__address      = bus.dma__memc__write_address[int'(win_lane)*ADDR_W +: ADDR_W];
        bus.arb__mem__write_data   = bus.dma__memc__write_data[int'(win_lane)*DATA_W +: DATA_W];
      end else begin
        bus.memc__dma__read_ready  = NUM_LANES'(1) << win_lane;
        bus.arb__mem__address      = bus.dma__memc__read_address[int'(win_lane)*ADDR_W +: ADDR_W];
      end
    end else if (ldst_go) begin
      bus.arb__mem__enable = 1'b1;
      bus.arb__mem__write  = ldst_wr;
      if (ldst_wr) begin
        bus.arb__mem__address    = bus.ldst__memc__write_address;
        bus.arb__mem__write_data = bus.ldst__memc__write_data;
      end else begin
        bus.arb__mem__address    = bus.ldst__memc__read_address;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      pipe_valid <= '0;
      pipe_ldst  <= '0;
      for (int k = 0; k < MEM_RD_LAT; k++) pipe_lane[k] <= '0;
    end else begin
      pipe_valid[0] <= push_valid;
      pipe_ldst[0]  <= push_ldst;
      pipe_lane[0]  <= win_lane;
      for (int k = 1; k < MEM_RD_LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_ldst[k]  <= pipe_ldst[k-1];
        pipe_lane[k]  <= pipe_lane[k-1];
      end
    end
  end

  // Anything still in flight after this cycle's return keeps DRAIN alive.
  always_comb begin
    pipe_hold = 1'b0;
    for (int k = 0; k < LAST; k++) pipe_hold = pipe_hold | pipe_valid[k];
  end

  assign ret_valid = pipe_valid[LAST] && !reset_poweron;

  always_comb begin
    bus.memc__dma__read_data_valid  = '0;
    bus.memc__dma__read_data        = '0;
    bus.memc__ldst__read_data_valid = 1'b0;
    bus.memc__ldst__read_data       = '0;
    if (ret_valid) begin
      if (pipe_ldst[LAST]) begin
        bus.memc__ldst__read_data_valid = 1'b1;
        bus.memc__ldst__read_data       = bus.mem__arb__read_data;
      end else begin
        bus.memc__dma__read_data_valid  = NUM_LANES'(1) << pipe_lane[LAST];
        bus.memc__dma__read_data        = bus.mem__arb__read_data;
      end
    end
  end

  assign bus.memc__ldst__granted = (state == ST_LDST_OWN) && !reset_poweron;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state    <= ST_DMA;
      rr_ptr   <= '0;
      dma_turn <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      dma_turn <= dma_turn_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    dma_turn_nxt = dma_turn;
    case (state)
      ST_DMA: begin
        dma_turn_nxt = 1'b0;
        if (dma_go) begin
          rr_ptr_nxt = (int'(win_lane) == NUM_LANES - 1) ? '0 : win_lane + LW'(1);
        end
        if (ldst_req_seen) begin
          state_nxt = pipe_hold ? ST_DRAIN : ST_LDST_OWN;
        end
      end
      ST_DRAIN: begin
        if (!bus.ldst__memc__request) begin
          state_nxt = ST_DMA;
        end else if (!pipe_hold) begin
          state_nxt = ST_LDST_OWN;
        end
      end
      ST_LDST_OWN: begin
        if (bus.ldst__memc__released) begin
          state_nxt    = ST_DMA;
          dma_turn_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_DMA;
    endcase
  end

endmodule
